// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq -- instruction fetch/sequencer for the 8-bit RISC core.
// Holds the PC, fetches from program memory into the IR and hands
// {opcode, operand} to the controller once per instruction (4 cycles:
// ADDR, DATA, DECODE, EXEC). JMP and SKZ are resolved here.
//
// Optional feature macro: SINGLE_STEP_EN (adds step/paused and an S_PAUSE
// state entered after every S_EXEC).
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   load_in           program-load mode; fetch suspended, pc parked at RESET_PC
//   acc_zero          accumulator == 0, used by SKZ in S_EXEC
//   mem_rdata         memory read data, valid the cycle after mem_rd
//   mem_addr, mem_rd  memory address / read strobe
//   opcode            IR[7:5] while instr_vld, otherwise 000
//   operand           IR[ADDR_W-1:0]
//   instr_vld         high for the single decode cycle
//   halted            high while stopped on HLT
//   pc                program counter
//   step, paused      (SINGLE_STEP_EN only) advance pulse / waiting for step
module instr_fetch_seq #(
   parameter int                ADDR_W   = 5,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_in,
   input  logic              acc_zero,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic [2:0]        opcode,
   output logic [ADDR_W-1:0] operand,
   output logic              instr_vld,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
`ifdef SINGLE_STEP_EN
   ,
   output logic              paused
`endif
);

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      S_ADDR, S_DATA, S_DECODE, S_EXEC, S_HALT, S_LOAD
`ifdef SINGLE_STEP_EN
      , S_PAUSE
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   // go_q is low only in the first cycle out of reset: the reset state is
   // S_ADDR but the read strobe must stay low while reset is applied, so the
   // first fetch is issued one cycle after release.
   logic                go_q, go_d;
   logic [ADDR_W-1:0]   pc_inc;
   logic [2:0]          ir_op;

   assign pc_inc = pc_q + ADDR_W'(1);
   assign ir_op  = ir_q[DATA_W-1 -: 3];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_ADDR;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         go_q    <= go_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      go_d    = 1'b1;
      case (state_q)
         S_ADDR:   if (go_q) state_d = S_DATA;
         S_DATA: begin
            ir_d    = mem_rdata;
            pc_d    = pc_inc;
            state_d = S_DECODE;
         end
         S_DECODE: state_d = (ir_op == OP_HLT) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (ir_op == OP_JMP)
               pc_d = ir_q[ADDR_W-1:0];
            else if (ir_op == OP_SKZ && acc_zero)
               pc_d = pc_inc;
`ifdef SINGLE_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_ADDR;
`endif
         end
         S_HALT:   state_d = S_HALT;
         S_LOAD: begin
            pc_d    = RESET_PC;
            state_d = S_ADDR;
         end
`ifdef SINGLE_STEP_EN
         S_PAUSE:  if (step) state_d = S_ADDR;
`endif
         default:  state_d = S_ADDR;
      endcase
      // Load mode wins from any state and discards the in-flight instruction.
      if (load_in) begin
         state_d = S_LOAD;
         pc_d    = RESET_PC;
         ir_d    = '0;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_rd    = 1'b0;
      opcode    = OP_HLT;
      instr_vld = 1'b0;
      halted    = 1'b0;
`ifdef SINGLE_STEP_EN
      paused    = 1'b0;
`endif
      case (state_q)
         S_ADDR: begin
            mem_addr = go_q ? pc_q : '0;
            mem_rd   = go_q;
         end
         S_DECODE: begin
            instr_vld = 1'b1;
            opcode    = ir_op;
         end
         S_EXEC: begin
            mem_addr = ir_q[ADDR_W-1:0];
            case (ir_op)
               OP_ADD, OP_AND, OP_XOR, OP_LDA: mem_rd = 1'b1;
               default:                        mem_rd = 1'b0;
            endcase
         end
         S_HALT:   halted = 1'b1;
`ifdef SINGLE_STEP_EN
         S_PAUSE:  paused = 1'b1;
`endif
         default: ;
      endcase
   end

   assign operand = ir_q[ADDR_W-1:0];
   assign pc      = pc_q;

endmodule
